// File: rtl/ice51_data_dump.sv
// Mirror of the ice51 core's data RAM with a UART dump engine.
// Core writes always land; a dump serialises a contiguous address range as 8N1 frames.
module ice51_data_dump #(
  parameter int unsigned SAMPLE = 104,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_data_wr,
  input  logic [$clog2(DEPTH)-1:0]   i_data_addr,
  input  logic [7:0]                 i_data_data,
  input  logic                       i_dump_start,
  input  logic [$clog2(DEPTH)-1:0]   i_dump_base,
  input  logic [$clog2(DEPTH):0]     i_dump_len,
  output logic                       o_uart_tx,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE - 1);
  localparam logic [AW:0]     MaxLen = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StRead, StLoad, StStart, StData, StStop} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [AW:0]     r_rem;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_rdata;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_mem [DEPTH];

  logic [AW:0]     w_len;

  assign w_len = (i_dump_len > MaxLen) ? MaxLen : i_dump_len;

  // No reset on the array so it maps onto block RAM and survives a reset.
  always_ff @(posedge i_clk) begin
    if (i_data_wr) r_mem[i_data_addr] <= i_data_data;
    if (r_state == StRead) r_rdata <= r_mem[r_addr];
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tx   <= 1'b1;
      case (r_state)
        StIdle: begin
          if (i_dump_start) begin
            if (w_len != '0) begin
              r_addr  <= i_dump_base;
              r_rem   <= w_len;
              r_busy  <= 1'b1;
              r_state <= StRead;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        StRead: r_state <= StLoad;
        StLoad: begin
          r_shift <= r_rdata;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= StStart;
        end
        StStart: begin
          r_tx <= 1'b0;
          if (r_cnt == CntMax) begin
            r_cnt   <= '0;
            r_state <= StData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          r_tx <= r_shift[0];
          if (r_cnt == CntMax) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) r_state <= StStop;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_cnt == CntMax) begin
            r_cnt  <= '0;
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == (AW + 1)'(1)) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRead;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_uart_tx = r_tx;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_ice51_data_dump.sv
// Directed bench for ice51_data_dump: a free-running UART receiver collects frames,
// the main sequence drives core writes and dump requests and compares against fixed values.
module tb_ice51_data_dump;

  localparam int unsigned S = 10;

  logic       i_clk;
  logic       i_nrst;
  logic       i_data_wr;
  logic [8:0] i_data_addr;
  logic [7:0] i_data_data;
  logic       i_dump_start;
  logic [8:0] i_dump_base;
  logic [9:0] i_dump_len;
  logic       o_uart_tx;
  logic       o_busy;
  logic       o_done;

  ice51_data_dump #(.SAMPLE(S), .DEPTH(512)) u_dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_data_wr    (i_data_wr),
    .i_data_addr  (i_data_addr),
    .i_data_data  (i_data_data),
    .i_dump_start (i_dump_start),
    .i_dump_base  (i_dump_base),
    .i_dump_len   (i_dump_len),
    .o_uart_tx    (o_uart_tx),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int rx_ferr  = 0;
  logic [7:0] rx_q [$];
  int         rx_t [$];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (o_done === 1'b1) done_cnt <= done_cnt + 1;

  // Receiver: detect start on a falling level, sample mid-bit.
  initial begin
    logic [7:0] b;
    int         t;
    forever begin
      @(negedge i_clk);
      if (o_uart_tx === 1'b0) begin
        t = cyc;
        repeat (S / 2) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (S) @(negedge i_clk);
          b[i] = o_uart_tx;
        end
        repeat (S) @(negedge i_clk);
        if (o_uart_tx !== 1'b1) rx_ferr = rx_ferr + 1;
        rx_q.push_back(b);
        rx_t.push_back(t);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_ram(input logic [8:0] a, input logic [7:0] d);
    i_data_wr   = 1'b1;
    i_data_addr = a;
    i_data_data = d;
    tick();
    i_data_wr   = 1'b0;
  endtask

  task automatic start_dump(input logic [8:0] base, input logic [9:0] len);
    i_dump_start = 1'b1;
    i_dump_base  = base;
    i_dump_len   = len;
    tick();
    i_dump_start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("frames_arrive", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (o_busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check("idle_reached", 32'(o_busy), 32'd0);
    tick();
  endtask

  function automatic logic [7:0] pat(input int a);
    logic [8:0] x;
    x = 9'(a);
    return x[7:0] ^ (x[8] ? 8'hAA : 8'h2A);
  endfunction

  initial begin
    int         idx;
    int         d0;
    int         bad;
    int         done_at;
    int         done_n;
    logic       busy_bad;
    logic       bit_bad;
    logic       expb;
    logic [7:0] byte55;

    i_nrst       = 1'b0;
    i_data_wr    = 1'b0;
    i_data_addr  = '0;
    i_data_data  = '0;
    i_dump_start = 1'b0;
    i_dump_base  = '0;
    i_dump_len   = '0;
    repeat (3) tick();
    check("rst_tx", 32'(o_uart_tx), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    i_nrst = 1'b1;
    tick();

    // Single byte, cycle-exact
    byte55 = 8'h55;
    write_ram(9'h010, byte55);
    tick();
    start_dump(9'h010, 10'd1);
    check("sb_e0_tx", 32'(o_uart_tx), 32'd1);
    check("sb_e0_busy", 32'(o_busy), 32'd1);
    tick();
    check("sb_e1_tx", 32'(o_uart_tx), 32'd1);
    tick();
    check("sb_e2_tx", 32'(o_uart_tx), 32'd1);
    tick();
    busy_bad = 1'b0;
    done_at  = -1;
    done_n   = 0;
    for (int b = 0; b < 10; b++) begin
      expb    = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byte55[b-1];
      bit_bad = 1'b0;
      for (int c = 0; c < int'(S); c++) begin
        if (o_uart_tx !== expb) bit_bad = 1'b1;
        if (b * int'(S) + c < 10 * int'(S) - 1 && o_busy !== 1'b1) busy_bad = 1'b1;
        if (o_done === 1'b1) begin
          done_at = b * int'(S) + c;
          done_n++;
        end
        tick();
      end
      check($sformatf("sb_bit%0d", b), 32'(bit_bad), 32'd0);
    end
    check("sb_busy_frame", 32'(busy_bad), 32'd0);
    check("sb_done_count", 32'(done_n), 32'd1);
    check("sb_done_time", 32'(done_at), 32'(10 * S - 1));
    check("sb_done_low", 32'(o_done), 32'd0);
    check("sb_busy_low", 32'(o_busy), 32'd0);
    repeat (5) tick();

    // Address wrap
    write_ram(9'h1FF, 8'hA1);
    write_ram(9'h000, 8'hB2);
    idx = rx_q.size();
    d0  = done_cnt;
    start_dump(9'h1FF, 10'd2);
    wait_frames(idx + 2, 2 * (10 * S + 2) + 50);
    check("wrap_b0", 32'(rx_q[idx]), 32'hA1);
    check("wrap_b1", 32'(rx_q[idx+1]), 32'hB2);
    check("wrap_gap", 32'(rx_t[idx+1] - rx_t[idx]), 32'(10 * S + 2));
    wait_idle(50);
    check("wrap_done", 32'(done_cnt - d0), 32'd1);

    // Zero length
    idx = rx_q.size();
    start_dump(9'h020, 10'd0);
    check("zl_done", 32'(o_done), 32'd1);
    check("zl_busy", 32'(o_busy), 32'd0);
    tick();
    check("zl_done_low", 32'(o_done), 32'd0);
    busy_bad = 1'b0;
    for (int k = 0; k < 3 * int'(S); k++) begin
      if (o_busy !== 1'b0 || o_uart_tx !== 1'b1) busy_bad = 1'b1;
      tick();
    end
    check("zl_quiet", 32'(busy_bad), 32'd0);
    check("zl_no_frame", 32'(rx_q.size()), 32'(idx));

    // Busy-ignore and live write
    write_ram(9'h000, 8'h11);
    write_ram(9'h001, 8'h22);
    write_ram(9'h002, 8'h33);
    write_ram(9'h003, 8'h44);
    write_ram(9'h100, 8'h5A);
    idx = rx_q.size();
    d0  = done_cnt;
    start_dump(9'h000, 10'd4);
    repeat (3 * S) tick();
    start_dump(9'h100, 10'd1);
    check("bi_busy", 32'(o_busy), 32'd1);
    repeat (10 * S) tick();
    write_ram(9'h003, 8'h99);
    wait_frames(idx + 4, 4 * (10 * S + 2) + 50);
    check("bi_b0", 32'(rx_q[idx]), 32'h11);
    check("bi_b1", 32'(rx_q[idx+1]), 32'h22);
    check("bi_b2", 32'(rx_q[idx+2]), 32'h33);
    check("bi_b3", 32'(rx_q[idx+3]), 32'h99);
    wait_idle(50);
    repeat (3 * 10 * S) tick();
    check("bi_count", 32'(rx_q.size()), 32'(idx + 4));
    check("bi_done", 32'(done_cnt - d0), 32'd1);

    // Length clamp
    for (int a = 0; a < 512; a++) write_ram(9'(a), pat(a));
    idx = rx_q.size();
    d0  = done_cnt;
    start_dump(9'h123, 10'h3FF);
    wait_frames(idx + 512, 512 * (10 * S + 2) + 100);
    wait_idle(100);
    repeat (3 * 10 * S) tick();
    check("cl_count", 32'(rx_q.size()), 32'(idx + 512));
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (rx_q[idx+i] !== pat((9'h123 + i) % 512)) bad++;
    check("cl_data", 32'(bad), 32'd0);
    check("cl_done", 32'(done_cnt - d0), 32'd1);

    // Reset during data bit 3 (byte 0x62, bit 3 is 0)
    d0 = done_cnt;
    start_dump(9'h048, 10'd2);
    repeat (44) tick();
    check("rs_pre_tx", 32'(o_uart_tx), 32'd0);
    i_nrst = 1'b0;
    #1;
    check("rs_tx", 32'(o_uart_tx), 32'd1);
    check("rs_busy", 32'(o_busy), 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    repeat (12 * S) tick();
    check("rs_no_done", 32'(done_cnt - d0), 32'd0);
    check("rs_idle_tx", 32'(o_uart_tx), 32'd1);
    idx = rx_q.size();
    start_dump(9'h048, 10'd2);
    wait_frames(idx + 2, 2 * (10 * S + 2) + 50);
    check("rs_b0", 32'(rx_q[idx]), 32'h62);
    check("rs_b1", 32'(rx_q[idx+1]), 32'h63);
    wait_idle(50);
    check("framing", 32'(rx_ferr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
